// File: rtl/mem_access.sv
// mem_access: memory-access stage of the RV32 pipeline.
// Puts loads and stores onto a ready/ack data-memory port. It holds the front
// of the pipeline (stall) until the transaction completes. The load result,
// aligned and extended, goes to valM for writeback.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   regM_i_mem_rd/wr      M-stage instruction is a load / store (load wins if both)
//   regM_i_funct3         access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
//   regM_i_valE           effective address
//   regM_i_valB           store data (rs2)
//   memory_o_valM         aligned, extended load result (0 after a store)
//   memory_o_stall        holds F/D/E/M and bubbles W
//   memory_o_misalign     one-cycle pulse on a rejected misaligned access
//                         (exists only when MEM_MISALIGN_CHECK_EN is defined)
//   dmem_o_*              bus request, write enable, word address, lane data, strobes
//   dmem_i_ack/rdata      completion, with read data valid in the same cycle
//
// Build option: MEM_MISALIGN_CHECK_EN. When it is defined, misaligned halfword
// and word accesses are trapped locally. When it is not defined, the low
// address bits that a wider access cannot use are dropped.
module mem_access #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              regM_i_mem_rd,
  input  logic              regM_i_mem_wr,
  input  logic [2:0]        regM_i_funct3,
  input  logic [31:0]       regM_i_valE,
  input  logic [31:0]       regM_i_valB,
  output logic [31:0]       memory_o_valM,
  output logic              memory_o_stall,
`ifdef MEM_MISALIGN_CHECK_EN
  output logic              memory_o_misalign,
`endif
  output logic              dmem_o_req,
  output logic              dmem_o_we,
  output logic [ADDR_W-1:0] dmem_o_addr,
  output logic [31:0]       dmem_o_wdata,
  output logic [3:0]        dmem_o_wstrb,
  input  logic              dmem_i_ack,
  input  logic [31:0]       dmem_i_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [31:0]         valm_q, valm_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;
  logic [1:0]          off_q, off_d;
  logic [2:0]          f3_q, f3_d;
`ifdef MEM_MISALIGN_CHECK_EN
  logic                mis_q, mis_d;
  logic                misaligned;
`endif

  logic        op;
  logic [1:0]  size;
  logic [1:0]  off_eff;
  logic [31:0] rd_shift;
  logic [31:0] ext;

  assign op   = regM_i_mem_rd | regM_i_mem_wr;
  assign size = regM_i_funct3[1:0];

  // Byte offset actually used: a halfword drops a[0] and a word drops a[1:0].
  // With the check enabled, offsets that would be dropped never reach the bus.
  always_comb begin
    case (size)
      2'b00:   off_eff = regM_i_valE[1:0];
      2'b01:   off_eff = {regM_i_valE[1], 1'b0};
      default: off_eff = 2'b00;
    endcase
  end

`ifdef MEM_MISALIGN_CHECK_EN
  assign misaligned = ((size == 2'b01) && regM_i_valE[0]) ||
                      (size[1] && (regM_i_valE[1:0] != 2'b00));
`endif

  // Load extraction works on the latched offset and size. The M inputs are
  // held by the stall anyway, but the latched copy keeps the datapath local.
  assign rd_shift = dmem_i_rdata >> {off_q, 3'b000};
  always_comb begin
    case (f3_q[1:0])
      2'b00:   ext = {{24{rd_shift[7]  & ~f3_q[2]}}, rd_shift[7:0]};
      2'b01:   ext = {{16{rd_shift[15] & ~f3_q[2]}}, rd_shift[15:0]};
      default: ext = rd_shift;
    endcase
  end

  always_comb begin
    state_d = state_q;
    valm_d  = valm_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    off_d   = off_q;
    f3_d    = f3_q;
`ifdef MEM_MISALIGN_CHECK_EN
    mis_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (op) begin
          we_d   = regM_i_mem_wr & ~regM_i_mem_rd;
          addr_d = {regM_i_valE[ADDR_W-1:2], 2'b00};
          off_d  = off_eff;
          f3_d   = regM_i_funct3;
          case (size)
            2'b00: begin
              wdata_d = {4{regM_i_valB[7:0]}};
              wstrb_d = 4'b0001 << off_eff;
            end
            2'b01: begin
              wdata_d = {2{regM_i_valB[15:0]}};
              wstrb_d = 4'b0011 << off_eff;
            end
            default: begin
              wdata_d = regM_i_valB;
              wstrb_d = 4'b1111;
            end
          endcase
`ifdef MEM_MISALIGN_CHECK_EN
          if (misaligned) begin
            // Trap locally: no bus cycle, result forced to zero.
            state_d = S_DONE;
            valm_d  = 32'h0;
            mis_d   = 1'b1;
          end else
`endif
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (dmem_i_ack) begin
          state_d = S_DONE;
          valm_d  = we_q ? 32'h0 : ext;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      valm_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      off_q   <= '0;
      f3_q    <= '0;
`ifdef MEM_MISALIGN_CHECK_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      valm_q  <= valm_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
`ifdef MEM_MISALIGN_CHECK_EN
      mis_q   <= mis_d;
`endif
    end
  end

  // DONE is the release cycle: the op is still in M, but M advances at its end.
  assign memory_o_stall = op && (state_q != S_DONE);
  assign memory_o_valM  = valm_q;
  assign dmem_o_req     = (state_q == S_REQ);
  assign dmem_o_we      = we_q;
  assign dmem_o_addr    = addr_q;
  assign dmem_o_wdata   = wdata_q;
  assign dmem_o_wstrb   = wstrb_q;
`ifdef MEM_MISALIGN_CHECK_EN
  assign memory_o_misalign = mis_q;
`endif

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd, mem_wr;
  logic [2:0]  funct3;
  logic [31:0] val_e, val_b;
  logic [31:0] val_m;
  logic        stall;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        ack;
  logic [31:0] rdata;
`ifdef MEM_MISALIGN_CHECK_EN
  logic        misalign;
`endif

  int n_chk = 0;
  int n_pass = 0;

  mem_access #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .regM_i_mem_rd(mem_rd), .regM_i_mem_wr(mem_wr), .regM_i_funct3(funct3),
    .regM_i_valE(val_e), .regM_i_valB(val_b),
    .memory_o_valM(val_m), .memory_o_stall(stall),
`ifdef MEM_MISALIGN_CHECK_EN
    .memory_o_misalign(misalign),
`endif
    .dmem_o_req(req), .dmem_o_we(we), .dmem_o_addr(addr),
    .dmem_o_wdata(wdata), .dmem_o_wstrb(wstrb),
    .dmem_i_ack(ack), .dmem_i_rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic no_op;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
  endtask

  // Runs one op from its IDLE cycle through the DONE cycle. Acks after dly
  // request cycles. Returns with the op still applied, in the DONE cycle.
  task automatic run_op(input string tag, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input int dly, input logic [31:0] rd_word,
                        input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_valm);
    tick;
    mem_rd = rd; mem_wr = wr; funct3 = f3; val_e = a; val_b = b;
    #1;
    chk({tag, " stall@N"}, {31'b0, stall}, 32'd1);
    chk({tag, " req@N"},   {31'b0, req},   32'd0);
    for (int i = 0; i <= dly; i++) begin
      tick;
      chk({tag, " req"},   {31'b0, req},   32'd1);
      chk({tag, " stall"}, {31'b0, stall}, 32'd1);
      chk({tag, " addr"},  addr,           exp_addr);
      chk({tag, " strb"},  {28'b0, wstrb}, {28'b0, exp_strb});
      chk({tag, " we"},    {31'b0, we},    {31'b0, wr & ~rd});
      if (wr & ~rd) chk({tag, " wdata"}, wdata, exp_wdata);
      if (i == dly) begin
        ack = 1'b1;
        rdata = rd_word;
      end
    end
    tick;
    ack = 1'b0;
    rdata = 32'h0;
    chk({tag, " req@done"},   {31'b0, req},   32'd0);
    chk({tag, " stall@done"}, {31'b0, stall}, 32'd0);
    chk({tag, " valM"},       val_m,          exp_valm);
  endtask

  initial begin
    rst = 1'b1; ack = 1'b0; rdata = '0;
    mem_rd = 1'b0; mem_wr = 1'b0; funct3 = '0; val_e = '0; val_b = '0;
    tick; tick;
    rst = 1'b0;
    #1;
    chk("rst valM",  val_m,          32'h0);
    chk("rst req",   {31'b0, req},   32'd0);
    chk("rst we",    {31'b0, we},    32'd0);
    chk("rst addr",  addr,           32'h0);
    chk("rst wdata", wdata,          32'h0);
    chk("rst strb",  {28'b0, wstrb}, 32'h0);
    chk("rst stall", {31'b0, stall}, 32'd0);
`ifdef MEM_MISALIGN_CHECK_EN
    chk("rst misalign", {31'b0, misalign}, 32'd0);
`endif

    // An ack outside REQ does nothing.
    ack = 1'b1; rdata = 32'hFFFFFFFF;
    tick;
    ack = 1'b0; rdata = 32'h0;
    chk("stray ack req",  {31'b0, req}, 32'd0);
    chk("stray ack valM", val_m,        32'h0);

    run_op("lw", 1, 0, 3'b010, 32'h100, 0, 0, 32'hDEADBEEF, 32'h100, 4'b1111, 0, 32'hDEADBEEF);
    no_op;
    run_op("lb", 1, 0, 3'b000, 32'h203, 0, 3, 32'h80FF0000, 32'h200, 4'b1000, 0, 32'hFFFFFF80);
    no_op;
    run_op("lhu", 1, 0, 3'b101, 32'h002, 0, 0, 32'h8001FFFF, 32'h000, 4'b1100, 0, 32'h00008001);
    no_op;
    run_op("sh", 0, 1, 3'b001, 32'h002, 32'h1234ABCD, 1, 32'h0, 32'h000, 4'b1100, 32'hABCDABCD, 32'h0);
    no_op;
    run_op("lbu", 1, 0, 3'b100, 32'h041, 0, 0, 32'h12C3F0AA, 32'h040, 4'b0010, 0, 32'h000000F0);
    // Both rd and wr set: the op is a load.
    run_op("rdwr", 1, 1, 3'b010, 32'h300, 32'h5555, 0, 32'h0BADF00D, 32'h300, 4'b1111, 0, 32'h0BADF00D);
    // Back-to-back: the second op sees IDLE right after the DONE cycle.
    run_op("b2b sb", 0, 1, 3'b000, 32'h004, 32'h000000A5, 0, 32'h0, 32'h004, 4'b0001, 32'hA5A5A5A5, 32'h0);
    run_op("b2b lw", 1, 0, 3'b010, 32'h008, 0, 0, 32'h11223344, 32'h008, 4'b1111, 0, 32'h11223344);
    no_op;

    // Reset while in REQ with the ack held back.
    tick;
    mem_rd = 1'b1; funct3 = 3'b010; val_e = 32'h010;
    tick;
    chk("rstreq req before", {31'b0, req}, 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rstreq req",   {31'b0, req},   32'd0);
    chk("rstreq valM",  val_m,          32'h0);
    chk("rstreq stall", {31'b0, stall}, 32'd1);
    ack = 1'b1; rdata = 32'h99;   // state is IDLE here, so this ack must be ignored
    tick;
    chk("rstreq rerequest", {31'b0, req}, 32'd1);
    chk("rstreq valM kept", val_m,        32'h0);
    rdata = 32'hCAFEF00D;
    tick;
    ack = 1'b0; rdata = 32'h0;
    chk("rstreq done valM",  val_m,          32'hCAFEF00D);
    chk("rstreq done stall", {31'b0, stall}, 32'd0);
    no_op;
    tick;
    chk("idle passthru valM",  val_m,          32'hCAFEF00D);
    chk("idle passthru stall", {31'b0, stall}, 32'd0);

`ifdef MEM_MISALIGN_CHECK_EN
    mem_rd = 1'b1; funct3 = 3'b010; val_e = 32'h102;
    #1;
    chk("mis stall@N", {31'b0, stall}, 32'd1);
    tick;
    chk("mis req",      {31'b0, req},      32'd0);
    chk("mis pulse",    {31'b0, misalign}, 32'd1);
    chk("mis valM",     val_m,             32'h0);
    chk("mis stall",    {31'b0, stall},    32'd0);
    no_op;
    tick;
    chk("mis pulse end", {31'b0, misalign}, 32'd0);
    chk("mis req end",   {31'b0, req},      32'd0);
`else
    run_op("lw mis", 1, 0, 3'b010, 32'h102, 0, 0, 32'h76543210, 32'h100, 4'b1111, 0, 32'h76543210);
    no_op;
    run_op("lh off3", 1, 0, 3'b001, 32'h003, 0, 0, 32'h8001FFFF, 32'h000, 4'b1100, 0, 32'hFFFF8001);
    no_op;
`endif

    tick;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
